// File: rtl/nic_rx_pkg.sv
// Shared definitions for the Rx interrupt moderation slice.
//   - register indices of the host write-only register map
//   - one-hot moderator FSM state encodings
//   - reset defaults for the programmable registers
package nic_rx_pkg;

   localparam logic [2:0] RX_REG_ACK    = 3'd0;
   localparam logic [2:0] RX_REG_CTRL   = 3'd1;
   localparam logic [2:0] RX_REG_PERIOD = 3'd2;
   localparam logic [2:0] RX_REG_THRESH = 3'd3;
   localparam logic [2:0] RX_REG_AGE    = 3'd4;
   localparam logic [2:0] RX_REG_CLR    = 3'd5;

   localparam logic [31:0] RX_DEF_PERIOD = 32'd62500;
   localparam logic [31:0] RX_DEF_THRESH = 32'd1;
   localparam logic [31:0] RX_DEF_AGE    = 32'd25000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b001,
      ST_ACCUM  = 3'b010,
      ST_ACTIVE = 3'b100
   } rx_state_e;

endpackage

// File: rtl/rx_irq_moderator_if.sv
// Bus bundle between the Rx DMA / host register path and the moderator.
//   commit_valid/commit_frames : frame commit strobe from the Rx DMA
//   reg_wr_en/addr/data        : host register write strobe
//   rx_activity, interrupts_enabled, interrupt_period,
//   pending_frames, ack_err    : moderator status toward the interrupt generator
interface rx_irq_moderator_if #(
   parameter int CNT_W = 32
);
   logic             commit_valid;
   logic [15:0]      commit_frames;
   logic             reg_wr_en;
   logic [2:0]       reg_wr_addr;
   logic [31:0]      reg_wr_data;
   logic             rx_activity;
   logic             interrupts_enabled;
   logic [31:0]      interrupt_period;
   logic [CNT_W-1:0] pending_frames;
   logic             ack_err;

   modport master (
      output commit_valid, commit_frames, reg_wr_en, reg_wr_addr, reg_wr_data,
      input  rx_activity, interrupts_enabled, interrupt_period, pending_frames, ack_err
   );

   modport slave (
      input  commit_valid, commit_frames, reg_wr_en, reg_wr_addr, reg_wr_data,
      output rx_activity, interrupts_enabled, interrupt_period, pending_frames, ack_err
   );
endinterface

// File: rtl/rx_reg_file.sv
// Host register decode for the Rx moderator.
//   clk, reset        : clock, synchronous active-low reset
//   wr_en_i/addr/data : host write strobe
//   ack_stb_o/ack_val_o : combinational ACK strobe and count
//   clr_stb_o         : combinational ack_err clear strobe
//   ctrl_en_o, period_o, thresh_o, age_limit_o : stored registers
module rx_reg_file
   import nic_rx_pkg::*;
#(
   parameter logic [31:0] DEF_PERIOD = RX_DEF_PERIOD,
   parameter logic [31:0] DEF_THRESH = RX_DEF_THRESH,
   parameter logic [31:0] DEF_AGE    = RX_DEF_AGE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en_i,
   input  logic [2:0]  wr_addr_i,
   input  logic [31:0] wr_data_i,
   output logic        ack_stb_o,
   output logic [31:0] ack_val_o,
   output logic        clr_stb_o,
   output logic        ctrl_en_o,
   output logic [31:0] period_o,
   output logic [31:0] thresh_o,
   output logic [31:0] age_limit_o
);

   logic        ctrl_q;
   logic [31:0] period_q;
   logic [31:0] thresh_q;
   logic [31:0] age_q;

   assign ack_stb_o = wr_en_i && (wr_addr_i == RX_REG_ACK);
   assign ack_val_o = wr_data_i;
   assign clr_stb_o = wr_en_i && (wr_addr_i == RX_REG_CLR);

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_q   <= 1'b0;
         period_q <= DEF_PERIOD;
         thresh_q <= DEF_THRESH;
         age_q    <= DEF_AGE;
      end else if (wr_en_i) begin
         case (wr_addr_i)
            RX_REG_CTRL:   ctrl_q   <= wr_data_i[0];
            RX_REG_PERIOD: period_q <= wr_data_i;
            RX_REG_THRESH: thresh_q <= wr_data_i;
            RX_REG_AGE:    age_q    <= wr_data_i;
            default: ;
         endcase
      end
   end

   assign ctrl_en_o   = ctrl_q;
   assign period_o    = period_q;
   assign thresh_o    = thresh_q;
   assign age_limit_o = age_q;

endmodule

// File: rtl/rx_irq_moderator.sv
// Rx interrupt moderator: counts frames committed by the Rx DMA against
// frames acknowledged by the host and raises the rx_activity level once
// enough frames are pending or the oldest pending frame has aged out.
//   clk, reset : clock, synchronous active-low reset
//   bus        : commit strobe, host writes in; activity/status out
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | nothing pending, age counter held at 0
// ST_ACCUM  | frames pending below threshold, age counter running
// ST_ACTIVE | rx_activity asserted until pending drains to 0
module rx_irq_moderator
   import nic_rx_pkg::*;
#(
   parameter int          CNT_W      = 32,
   parameter logic [31:0] DEF_PERIOD = RX_DEF_PERIOD,
   parameter logic [31:0] DEF_THRESH = RX_DEF_THRESH,
   parameter logic [31:0] DEF_AGE    = RX_DEF_AGE
) (
   input  logic clk,
   input  logic reset,
   rx_irq_moderator_if.slave bus
);

   // Wide enough to hold pending + commit and a full 32-bit ACK without loss.
   localparam int SW = CNT_W + 34;

   logic        ack_stb;
   logic [31:0] ack_val;
   logic        clr_stb;
   logic        ctrl_en;
   logic [31:0] period;
   logic [31:0] thresh;
   logic [31:0] age_limit;

   rx_reg_file #(
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_THRESH (DEF_THRESH),
      .DEF_AGE    (DEF_AGE)
   ) u_reg_file (
      .clk         (clk),
      .reset       (reset),
      .wr_en_i     (bus.reg_wr_en),
      .wr_addr_i   (bus.reg_wr_addr),
      .wr_data_i   (bus.reg_wr_data),
      .ack_stb_o   (ack_stb),
      .ack_val_o   (ack_val),
      .clr_stb_o   (clr_stb),
      .ctrl_en_o   (ctrl_en),
      .period_o    (period),
      .thresh_o    (thresh),
      .age_limit_o (age_limit)
   );

   logic [CNT_W-1:0] pending_q, pending_d;
   logic             ack_err_q, ack_err_d;
   logic [31:0]      age_q, age_d;
   rx_state_e        state_q, state_d;

   logic [SW-1:0] sum_w, ack_w, diff_w;
   logic          underflow;
   logic [31:0]   eff_thresh;
   logic          reach, nonzero, age_hit;

   always_comb begin
      sum_w     = SW'(pending_q) + (bus.commit_valid ? SW'(bus.commit_frames) : '0);
      ack_w     = ack_stb ? SW'(ack_val) : '0;
      underflow = ack_w > sum_w;
      diff_w    = sum_w - ack_w;
      if (underflow) begin
         pending_d = '0;
      end else if (diff_w > SW'({CNT_W{1'b1}})) begin
         pending_d = '1;
      end else begin
         pending_d = diff_w[CNT_W-1:0];
      end
      // CLR and ACK share the write port, so they never coincide.
      ack_err_d = clr_stb ? 1'b0 : (ack_err_q | underflow);
   end

   // FSM decisions use the post-update count so activity tracks the strobe
   // with a single cycle of latency.
   always_comb begin
      eff_thresh = (thresh == 32'd0) ? 32'd1 : thresh;
      reach      = SW'(pending_d) >= SW'(eff_thresh);
      nonzero    = pending_d != '0;
      age_hit    = (age_limit != 32'd0) && (age_q == age_limit - 32'd1);

      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (reach)        state_d = ST_ACTIVE;
            else if (nonzero) state_d = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (!nonzero)     state_d = ST_IDLE;
            else if (reach)   state_d = ST_ACTIVE;
            else if (age_hit) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (!nonzero)     state_d = ST_IDLE;
         end
         default:             state_d = ST_IDLE;
      endcase

      // Counter starts at 0 on ACCUM entry and is cleared whenever we leave.
      age_d = ((state_q == ST_ACCUM) && (state_d == ST_ACCUM)) ? age_q + 32'd1 : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pending_q <= '0;
         ack_err_q <= 1'b0;
         age_q     <= 32'd0;
         state_q   <= ST_IDLE;
      end else begin
         pending_q <= pending_d;
         ack_err_q <= ack_err_d;
         age_q     <= age_d;
         state_q   <= state_d;
      end
   end

   assign bus.rx_activity        = (state_q == ST_ACTIVE);
   assign bus.interrupts_enabled = ctrl_en;
   assign bus.interrupt_period   = period;
   assign bus.pending_frames     = pending_q;
   assign bus.ack_err            = ack_err_q;

endmodule

// File: tb/tb_rx_irq_moderator.sv
module tb_rx_irq_moderator;

   localparam longint MAXP = 64'h0000_0000_FFFF_FFFF;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rx_irq_moderator_if #(.CNT_W(32)) bus ();

   rx_irq_moderator #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending as plain integer arithmetic, moderation as
   // "active / accumulating since cycle X" with elapsed-time comparison.
   longint m_pend;
   bit     m_err, m_ie, m_act, m_acc;
   longint m_per, m_thr, m_age, m_start, cyc;

   task automatic model_step();
      longint nx, eff;
      bit     uf;
      cyc = cyc + 1;
      if (!rst_n) begin
         m_pend = 0; m_err = 0; m_ie = 0; m_act = 0; m_acc = 0;
         m_per = 62500; m_thr = 1; m_age = 25000; m_start = 0;
         return;
      end
      nx = m_pend + (bus.commit_valid ? longint'(bus.commit_frames) : 0)
                  - ((bus.reg_wr_en && bus.reg_wr_addr == 3'd0) ? longint'(bus.reg_wr_data) : 0);
      uf = nx < 0;
      if (uf) nx = 0;
      if (nx > MAXP) nx = MAXP;
      eff = (m_thr == 0) ? 1 : m_thr;
      if (m_act) begin
         if (nx == 0) m_act = 0;
      end else if (m_acc) begin
         if (nx == 0) m_acc = 0;
         else if (nx >= eff || (m_age != 0 && (cyc - 1 - m_start) == m_age - 1)) begin
            m_act = 1; m_acc = 0;
         end
      end else begin
         if (nx >= eff) m_act = 1;
         else if (nx > 0) begin m_acc = 1; m_start = cyc; end
      end
      if (bus.reg_wr_en && bus.reg_wr_addr == 3'd5) m_err = 0;
      else if (uf) m_err = 1;
      if (bus.reg_wr_en) begin
         case (bus.reg_wr_addr)
            3'd1: m_ie  = bus.reg_wr_data[0];
            3'd2: m_per = longint'(bus.reg_wr_data);
            3'd3: m_thr = longint'(bus.reg_wr_data);
            3'd4: m_age = longint'(bus.reg_wr_data);
            default: ;
         endcase
      end
      m_pend = nx;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step(input bit cv, input logic [15:0] cf, input bit we,
                       input logic [2:0] wa, input logic [31:0] wd);
      bus.commit_valid  = cv;
      bus.commit_frames = cf;
      bus.reg_wr_en     = we;
      bus.reg_wr_addr   = wa;
      bus.reg_wr_data   = wd;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      step(0, 16'd0, 0, 3'd0, 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pending"}, 64'(bus.pending_frames), 64'(m_pend));
      chk({tag, ".act"},     64'(bus.rx_activity), 64'(m_act));
      chk({tag, ".err"},     64'(bus.ack_err), 64'(m_err));
      chk({tag, ".ie"},      64'(bus.interrupts_enabled), 64'(m_ie));
      chk({tag, ".period"},  64'(bus.interrupt_period), 64'(m_per));
   endtask

   typedef struct {
      bit          cv;
      logic [15:0] cf;
      bit          we;
      logic [2:0]  wa;
      logic [31:0] wd;
      logic [31:0] pend;
      bit          act;
      bit          err;
      bit          ie;
      logic [31:0] per;
   } vec_t;

   vec_t tbl[18];

   initial begin
      int rise;
      bit rose;
      checks = 0;
      errors = 0;
      cyc    = 0;

      //          cv cf we wa wd     pend act err ie per
      tbl[0]  = '{0, 0, 1, 3, 4,     0,   0,  0,  0, 62500};
      tbl[1]  = '{1, 1, 0, 0, 0,     1,   0,  0,  0, 62500};
      tbl[2]  = '{0, 0, 0, 0, 0,     1,   0,  0,  0, 62500};
      tbl[3]  = '{1, 1, 0, 0, 0,     2,   0,  0,  0, 62500};
      tbl[4]  = '{1, 1, 0, 0, 0,     3,   0,  0,  0, 62500};
      tbl[5]  = '{1, 1, 0, 0, 0,     4,   1,  0,  0, 62500};
      tbl[6]  = '{0, 0, 1, 0, 4,     0,   0,  0,  0, 62500};
      tbl[7]  = '{1, 5, 0, 0, 0,     5,   1,  0,  0, 62500};
      tbl[8]  = '{1, 3, 1, 0, 5,     3,   1,  0,  0, 62500};
      tbl[9]  = '{0, 0, 1, 0, 1,     2,   1,  0,  0, 62500};
      tbl[10] = '{0, 0, 1, 0, 7,     0,   0,  1,  0, 62500};
      tbl[11] = '{0, 0, 1, 5, 0,     0,   0,  0,  0, 62500};
      tbl[12] = '{0, 0, 1, 1, 1,     0,   0,  0,  1, 62500};
      tbl[13] = '{0, 0, 1, 2, 1000,  0,   0,  0,  1, 1000};
      tbl[14] = '{0, 0, 1, 6, 0,     0,   0,  0,  1, 1000};
      tbl[15] = '{0, 0, 1, 7, 32'hFFFF_FFFF, 0, 0, 0, 1, 1000};
      tbl[16] = '{1, 2, 0, 0, 0,     2,   0,  0,  1, 1000};
      tbl[17] = '{0, 0, 1, 0, 2,     0,   0,  0,  1, 1000};

      rst_n = 1'b0;
      idle();
      idle();
      rst_n = 1'b1;
      chk("rst.pending", 64'(bus.pending_frames), 64'd0);
      chk("rst.act",     64'(bus.rx_activity), 64'd0);
      chk("rst.err",     64'(bus.ack_err), 64'd0);
      chk("rst.ie",      64'(bus.interrupts_enabled), 64'd0);
      chk("rst.period",  64'(bus.interrupt_period), 64'd62500);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].cv, tbl[i].cf, tbl[i].we, tbl[i].wa, tbl[i].wd);
         chk($sformatf("vec%0d.pending", i), 64'(bus.pending_frames), 64'(tbl[i].pend));
         chk($sformatf("vec%0d.act", i),     64'(bus.rx_activity), 64'(tbl[i].act));
         chk($sformatf("vec%0d.err", i),     64'(bus.ack_err), 64'(tbl[i].err));
         chk($sformatf("vec%0d.ie", i),      64'(bus.interrupts_enabled), 64'(tbl[i].ie));
         chk($sformatf("vec%0d.period", i),  64'(bus.interrupt_period), 64'(tbl[i].per));
      end

      // Age timeout: activity rises 100 cycles after ACCUM entry.
      do_reset();
      step(0, 16'd0, 1, 3'd3, 32'd8);
      step(0, 16'd0, 1, 3'd4, 32'd100);
      step(1, 16'd2, 0, 3'd0, 32'd0);
      chk("age.accum_act", 64'(bus.rx_activity), 64'd0);
      rise = -1;
      for (int j = 1; j <= 200 && rise < 0; j++) begin
         idle();
         if (bus.rx_activity) rise = j;
      end
      chk("age.rise_cycle", 64'(rise), 64'd100);
      chk("age.pending", 64'(bus.pending_frames), 64'd2);

      // AGE=0: threshold only, never rises below it.
      do_reset();
      step(0, 16'd0, 1, 3'd3, 32'd8);
      step(0, 16'd0, 1, 3'd4, 32'd0);
      step(1, 16'd2, 0, 3'd0, 32'd0);
      rose = 0;
      for (int j = 0; j < 300; j++) begin
         idle();
         if (bus.rx_activity) rose = 1;
      end
      chk("age0.never_rose", 64'(rose), 64'd0);
      chk("age0.pending", 64'(bus.pending_frames), 64'd2);

      // Reset mid-operation while ACTIVE.
      do_reset();
      step(0, 16'd0, 1, 3'd1, 32'd1);
      step(1, 16'd10, 0, 3'd0, 32'd0);
      chk("mid.act", 64'(bus.rx_activity), 64'd1);
      chk("mid.pending", 64'(bus.pending_frames), 64'd10);
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      chk("mid_rst.pending", 64'(bus.pending_frames), 64'd0);
      chk("mid_rst.act",     64'(bus.rx_activity), 64'd0);
      chk("mid_rst.err",     64'(bus.ack_err), 64'd0);
      chk("mid_rst.ie",      64'(bus.interrupts_enabled), 64'd0);
      chk("mid_rst.period",  64'(bus.interrupt_period), 64'd62500);
      step(1, 16'd1, 0, 3'd0, 32'd0);
      chk("post_rst.act", 64'(bus.rx_activity), 64'd1);
      chk("post_rst.pending", 64'(bus.pending_frames), 64'd1);

      // Randomized traffic against the reference model.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         bit          cv, we;
         logic [15:0] cf;
         logic [2:0]  wa;
         logic [31:0] wd;
         cv = ($urandom_range(0, 99) < 35);
         cf = 16'($urandom_range(0, 6));
         we = ($urandom_range(0, 99) < 25);
         wa = 3'($urandom_range(0, 7));
         case (wa)
            3'd0:    wd = $urandom_range(0, 8);
            3'd3:    wd = $urandom_range(0, 7);
            3'd4:    wd = $urandom_range(0, 25);
            default: wd = $urandom;
         endcase
         rst_n = ($urandom_range(0, 199) != 0);
         step(cv, cf, we, wa, wd);
         chk_all($sformatf("rnd%0d", k));
      end
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
